// File: rtl/sp_ram_pkg.sv
// Shared types and defaults for the single-port RAM arbiter.
package sp_ram_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } owner_e;

endpackage

// File: rtl/rr2_burst_grant.sv
// Two-way round-robin grant with a burst limit that only applies while the
// other side is waiting. Pure control: no address or data paths.
module rr2_burst_grant
  import sp_ram_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_valid_i,
  input  logic rd_valid_i,
  output logic wr_gnt_o,
  output logic rd_gnt_o
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  owner_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_rd_q, last_rd_d;
  logic          wr_gnt_s, rd_gnt_s;

  // Owner, burst count and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  // Grant selection and next owner/count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_gnt_s = 1'b0;
    rd_gnt_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid_i && rd_valid_i) begin
          if (last_rd_q) begin
            wr_gnt_s = 1'b1;
            state_d  = WR;
          end else begin
            rd_gnt_s = 1'b1;
            state_d  = RD;
          end
          cnt_d = ONE_CNT;
        end else if (wr_valid_i) begin
          wr_gnt_s = 1'b1;
          state_d  = WR;
          cnt_d    = ONE_CNT;
        end else if (rd_valid_i) begin
          rd_gnt_s = 1'b1;
          state_d  = RD;
          cnt_d    = ONE_CNT;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WR: begin
        if (wr_valid_i && (!rd_valid_i || (cnt_q < MAX_CNT))) begin
          wr_gnt_s = 1'b1;
          // saturate so an uncontested stream never wraps the counter
          if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + ONE_CNT;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (rd_valid_i) begin
          rd_gnt_s = 1'b1;
          state_d  = RD;
          cnt_d    = ONE_CNT;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      RD: begin
        if (rd_valid_i && (!wr_valid_i || (cnt_q < MAX_CNT))) begin
          rd_gnt_s = 1'b1;
          if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + ONE_CNT;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (wr_valid_i) begin
          wr_gnt_s = 1'b1;
          state_d  = WR;
          cnt_d    = ONE_CNT;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Round-robin pointer follows every grant
  always_comb begin
    if (rd_gnt_s) begin
      last_rd_d = 1'b1;
    end else if (wr_gnt_s) begin
      last_rd_d = 1'b0;
    end else begin
      last_rd_d = last_rd_q;
    end
  end

  // Grants are forced low while reset is held so no request is accepted
  assign wr_gnt_o = wr_gnt_s & rst_n;
  assign rd_gnt_o = rd_gnt_s & rst_n;

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port synchronous-read RAM between a write and a read
// requester; RAM controls are registered, read data returns two cycles after grant.
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          ram_oe,
  input  logic [DW-1:0] ram_dout
);

  logic          wr_gnt_s, rd_gnt_s;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          ram_oe_q, ram_oe_d;
  logic          rd_pipe_q, rd_pipe_d;
  logic          rd_rvalid_q, rd_rvalid_d;

  rr2_burst_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk        (clk),
    .rst_n      (reset_n),
    .wr_valid_i (wr_valid),
    .rd_valid_i (rd_valid),
    .wr_gnt_o   (wr_gnt_s),
    .rd_gnt_o   (rd_gnt_s)
  );

  // RAM command and read-valid pipeline next state
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    if (wr_gnt_s) begin
      ram_addr_d = wr_addr;
      ram_din_d  = wr_data;
      ram_we_d   = 1'b1;
    end else if (rd_gnt_s) begin
      ram_addr_d = rd_addr;
      ram_oe_d   = 1'b1;
    end else begin
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
    end
    rd_pipe_d   = rd_gnt_s;
    rd_rvalid_d = rd_pipe_q;
  end

  // RAM-side output registers and two-stage read-valid delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      rd_pipe_q   <= 1'b0;
      rd_rvalid_q <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_rvalid_q <= rd_rvalid_d;
    end
  end

  assign wr_ready  = wr_gnt_s;
  assign rd_ready  = rd_gnt_s;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign rd_rvalid = rd_rvalid_q;
  assign rd_rdata  = ram_dout;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural RAM; directed
// transactions carry hand-computed expected grants, RAM commands and read data.
module tb_sp_ram_arbiter;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic       rd_ready;
  logic       rd_rvalid;
  logic [7:0] rd_rdata;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] ram_dout;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wreq_t;

  typedef struct {
    logic       we;
    logic       oe;
    logic [7:0] addr;
    logic [7:0] din;
  } ram_ev_t;

  wreq_t      wr_q[$];
  logic [7:0] rd_q[$];
  byte        exp_gnt[$];
  ram_ev_t    exp_ram[$];
  logic [7:0] exp_rd[$];
  logic [7:0] last_din;
  logic [7:0] mem [256];

  int vectors    = 0;
  int miscompares = 0;

  sp_ram_arbiter #(
    .AW        (8),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_dout  (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural single-port synchronous-read RAM
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_oe) ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
    exp_gnt.push_back("W");
    exp_ram.push_back('{we: 1'b1, oe: 1'b0, addr: a, din: d});
    last_din = d;
  endtask

  task automatic exp_r(input logic [7:0] a, input logic [7:0] rdata);
    exp_gnt.push_back("R");
    exp_ram.push_back('{we: 1'b0, oe: 1'b1, addr: a, din: last_din});
    exp_rd.push_back(rdata);
  endtask

  task automatic drive_inputs();
    wr_valid = (wr_q.size() > 0);
    if (wr_q.size() > 0) begin
      wr_addr = wr_q[0].addr;
      wr_data = wr_q[0].data;
    end
    rd_valid = (rd_q.size() > 0);
    if (rd_q.size() > 0) rd_addr = rd_q[0];
  endtask

  task automatic run_cycle();
    logic wacc, racc;
    drive_inputs();
    @(negedge clk);
    wacc = wr_valid && wr_ready;
    racc = rd_valid && rd_ready;
    @(posedge clk);
    #1;
    if (wacc) void'(wr_q.pop_front());
    if (racc) void'(rd_q.pop_front());
    drive_inputs();
  endtask

  task automatic run_until_empty(input string name, input int exp_cycles);
    int n = 0;
    while ((wr_q.size() > 0 || rd_q.size() > 0) && n < 200) begin
      run_cycle();
      n++;
    end
    chk(name, n, exp_cycles);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // monitor: compare every grant, RAM command and read return against the queues
  initial begin : monitor
    logic    prev_gnt;
    logic    prev_oe;
    byte     g;
    ram_ev_t e;
    prev_gnt = 1'b0;
    prev_oe  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_gnt = 1'b0;
        prev_oe  = 1'b0;
      end else begin
        if (wr_ready || rd_ready) begin
          chk("one_grant", {31'd0, wr_ready & rd_ready}, 32'd0);
          if (exp_gnt.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_unexpected: got wr=%0b rd=%0b, expected no grant", wr_ready, rd_ready);
          end else begin
            g = exp_gnt.pop_front();
            chk("grant_side", {24'd0, (wr_ready ? 8'h57 : 8'h52)}, {24'd0, g});
          end
        end
        if (ram_we || ram_oe) begin
          if (exp_ram.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ram_unexpected: got we=%0b oe=%0b addr=%0h, expected no access", ram_we, ram_oe, ram_addr);
          end else begin
            e = exp_ram.pop_front();
            chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
            chk("ram_oe", {31'd0, ram_oe}, {31'd0, e.oe});
            chk("ram_addr", {24'd0, ram_addr}, {24'd0, e.addr});
            chk("ram_din", {24'd0, ram_din}, {24'd0, e.din});
          end
          chk("ram_after_grant", {31'd0, prev_gnt}, 32'd1);
        end
        if (rd_rvalid) begin
          if (exp_rd.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rvalid_unexpected: got rdata=%0h, expected no rd_rvalid", rd_rdata);
          end else begin
            chk("rd_rdata", {24'd0, rd_rdata}, {24'd0, exp_rd.pop_front()});
          end
          chk("rvalid_after_oe", {31'd0, prev_oe}, 32'd1);
        end
        prev_gnt = (wr_valid && wr_ready) || (rd_valid && rd_ready);
        prev_oe  = ram_oe;
      end
    end
  end

  initial begin : stimulus
    last_din = 8'h00;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 8'h00;
    wr_data  = 8'h00;
    rd_valid = 1'b0;
    rd_addr  = 8'h00;

    // reset held with random requests: every output stays low
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      wr_valid = 1'($urandom_range(1, 0));
      rd_valid = 1'($urandom_range(1, 0));
      wr_addr  = 8'($urandom_range(255, 0));
      wr_data  = 8'($urandom_range(255, 0));
      rd_addr  = 8'($urandom_range(255, 0));
      @(negedge clk);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_oe", {31'd0, ram_oe}, 32'd0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("rst_ram_din", {24'd0, ram_din}, 32'd0);
      chk("rst_rd_rvalid", {31'd0, rd_rvalid}, 32'd0);
    end

    // contention from reset: W,W,W,W,R,R,R,R,W,W,R,R
    for (int i = 0; i < 6; i++) begin
      wr_q.push_back('{addr: 8'h10 + 8'(i), data: 8'hA0 + 8'(i)});
      rd_q.push_back(8'h10 + 8'(i));
    end
    exp_w(8'h10, 8'hA0); exp_w(8'h11, 8'hA1); exp_w(8'h12, 8'hA2); exp_w(8'h13, 8'hA3);
    exp_r(8'h10, 8'hA0); exp_r(8'h11, 8'hA1); exp_r(8'h12, 8'hA2); exp_r(8'h13, 8'hA3);
    exp_w(8'h14, 8'hA4); exp_w(8'h15, 8'hA5);
    exp_r(8'h14, 8'hA4); exp_r(8'h15, 8'hA5);
    @(posedge clk);
    #1;
    drive_inputs();
    reset_n = 1'b1;
    run_until_empty("contention_cycles", 12);
    run_idle(3);

    // uncontested write stream: six back-to-back grants
    for (int i = 0; i < 6; i++) wr_q.push_back('{addr: 8'(i), data: 8'(2 * i)});
    exp_w(8'h00, 8'h00); exp_w(8'h01, 8'h02); exp_w(8'h02, 8'h04);
    exp_w(8'h03, 8'h06); exp_w(8'h04, 8'h08); exp_w(8'h05, 8'h0A);
    run_until_empty("wr_stream_cycles", 6);
    run_idle(3);

    // readback of address 3
    rd_q.push_back(8'h03);
    exp_r(8'h03, 8'h06);
    run_until_empty("readback_cycles", 1);
    run_idle(3);

    // early release: reads arrive mid-burst and drop after two grants
    for (int i = 0; i < 9; i++) wr_q.push_back('{addr: 8'h20 + 8'(i), data: 8'hB0 + 8'(i)});
    exp_w(8'h20, 8'hB0); exp_w(8'h21, 8'hB1); exp_w(8'h22, 8'hB2); exp_w(8'h23, 8'hB3);
    exp_r(8'h20, 8'hB0); exp_r(8'h21, 8'hB1);
    exp_w(8'h24, 8'hB4); exp_w(8'h25, 8'hB5); exp_w(8'h26, 8'hB6); exp_w(8'h27, 8'hB7);
    exp_r(8'h24, 8'hB4); exp_r(8'h25, 8'hB5);
    exp_w(8'h28, 8'hB8);
    run_idle(2);
    chk("early_wr_left_a", wr_q.size(), 7);
    rd_q.push_back(8'h20);
    rd_q.push_back(8'h21);
    run_idle(5);
    chk("early_wr_left_b", wr_q.size(), 4);
    chk("early_rd_left_b", rd_q.size(), 0);
    rd_q.push_back(8'h24);
    rd_q.push_back(8'h25);
    run_until_empty("early_tail_cycles", 6);
    run_idle(3);

    // reset one cycle after a read grant: no data return for it
    rd_q.push_back(8'h03);
    exp_gnt.push_back("R");
    run_cycle();
    reset_n = 1'b0;
    drive_inputs();
    @(negedge clk);
    chk("midrst_rvalid_k1", {31'd0, rd_rvalid}, 32'd0);
    chk("midrst_oe_k1", {31'd0, ram_oe}, 32'd0);
    @(negedge clk);
    chk("midrst_rvalid_k2", {31'd0, rd_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_idle(4);
    chk("post_rst_we", {31'd0, ram_we}, 32'd0);
    chk("post_rst_oe", {31'd0, ram_oe}, 32'd0);
    chk("post_rst_rvalid", {31'd0, rd_rvalid}, 32'd0);

    chk("exp_gnt_drained", exp_gnt.size(), 0);
    chk("exp_ram_drained", exp_ram.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
